// File: rtl/sprite_ctrl_pkg.sv
// Shared constants and types for the sprite RAM write sequencer.
package sprite_ctrl_pkg;
   localparam int ADDR_W     = 9;
   localparam int DATA_W     = 3;
   localparam int RAM_DEPTH  = 512;
   localparam int FIFO_DEPTH = 8;

   typedef enum logic [1:0] {IDLE, DRAIN, FILL} sprite_ctrl_state_t;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } sprite_wr_t;
endpackage

// File: rtl/sprite_ram_ctrl_if.sv
// Pixel fetch, buffered write, fill command and RAM port signals of the sprite controller.
interface sprite_ram_ctrl_if;
   import sprite_ctrl_pkg::*;

   logic              blank;
   logic              pix_req;
   logic [ADDR_W-1:0] pix_addr;
   logic              pix_valid;
   logic [DATA_W-1:0] pix_data;
   logic              wr_req;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              wr_ready;
   logic              fill_start;
   logic [DATA_W-1:0] fill_color;
   logic              fill_busy;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_waddr;
   logic [DATA_W-1:0] ram_wdata;
   logic              ram_re;
   logic [ADDR_W-1:0] ram_raddr;
   logic [DATA_W-1:0] ram_rdata;

   modport slave (
      input  blank, pix_req, pix_addr, wr_req, wr_addr, wr_data,
             fill_start, fill_color, ram_rdata,
      output pix_valid, pix_data, wr_ready, fill_busy,
             ram_we, ram_waddr, ram_wdata, ram_re, ram_raddr
   );

   modport master (
      output blank, pix_req, pix_addr, wr_req, wr_addr, wr_data,
             fill_start, fill_color, ram_rdata,
      input  pix_valid, pix_data, wr_ready, fill_busy,
             ram_we, ram_waddr, ram_wdata, ram_re, ram_raddr
   );
endinterface

// File: rtl/sprite_wr_fifo.sv
// Synchronous FIFO holding pending sprite RAM writes until the next blanking window.
module sprite_wr_fifo
   import sprite_ctrl_pkg::*;
#(
   parameter int DEPTH = FIFO_DEPTH
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  sprite_wr_t               din,
   output sprite_wr_t               dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int PTR_W = $clog2(DEPTH);

   sprite_wr_t       mem_q [DEPTH];
   logic [PTR_W-1:0] wptr_q, wptr_d;
   logic [PTR_W-1:0] rptr_q, rptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             do_push, do_pop;

   // A push offered while full is refused even if a pop frees a slot that cycle.
   always_comb begin
      do_push = push && !full;
      do_pop  = pop && !empty;
      wptr_d  = wptr_q + PTR_W'(do_push);
      rptr_d  = rptr_q + PTR_W'(do_pop);
      count_d = count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clock) begin
      if (do_push) mem_q[wptr_q] <= din;
   end

   assign dout  = mem_q[rptr_q];
   assign full  = (count_q == (PTR_W+1)'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;
endmodule

// File: rtl/sprite_ram_ctrl.sv
// Sprite RAM write sequencer: blank-gated FIFO drain, full-RAM colour fill, pass-through pixel reads.
module sprite_ram_ctrl
   import sprite_ctrl_pkg::*;
(
   input  logic            clock,
   input  logic            reset,
   sprite_ram_ctrl_if.slave bus
);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   sprite_ctrl_state_t state_q, state_d;
   logic [ADDR_W-1:0]  fill_cnt_q, fill_cnt_d;
   logic [DATA_W-1:0]  fill_color_q, fill_color_d;
   logic               ram_we_q, ram_we_d;
   logic [ADDR_W-1:0]  ram_waddr_q, ram_waddr_d;
   logic [DATA_W-1:0]  ram_wdata_q, ram_wdata_d;
   logic               pix_valid_q, pix_valid_d;

   logic               push, pop, full, empty;
   logic [CNT_W-1:0]   count;
   sprite_wr_t         fifo_din, fifo_dout;

   assign push     = bus.wr_req && !full;
   assign fifo_din = {bus.wr_addr, bus.wr_data};

   sprite_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   (fifo_din),
      .dout  (fifo_dout),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   always_comb begin
      state_d      = state_q;
      fill_cnt_d   = fill_cnt_q;
      fill_color_d = fill_color_q;
      ram_we_d     = 1'b0;
      ram_waddr_d  = ram_waddr_q;
      ram_wdata_d  = ram_wdata_q;
      pix_valid_d  = bus.pix_req;
      pop          = 1'b0;
      unique case (state_q)
         IDLE: begin
            // A fill request wins over pending writes; they commit after the fill.
            if (bus.fill_start) begin
               state_d      = FILL;
               fill_color_d = bus.fill_color;
               fill_cnt_d   = '0;
            end else if (!empty) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (empty) begin
               state_d = IDLE;
            end else if (bus.blank) begin
               pop         = 1'b1;
               ram_we_d    = 1'b1;
               ram_waddr_d = fifo_dout.addr;
               ram_wdata_d = fifo_dout.data;
               if (count == CNT_W'(1) && !push) state_d = IDLE;
            end
         end
         FILL: begin
            if (bus.blank) begin
               ram_we_d    = 1'b1;
               ram_waddr_d = fill_cnt_q;
               ram_wdata_d = fill_color_q;
               if (fill_cnt_q == ADDR_W'(RAM_DEPTH - 1)) begin
                  fill_cnt_d = '0;
                  state_d    = (!empty || push) ? DRAIN : IDLE;
               end else begin
                  fill_cnt_d = fill_cnt_q + ADDR_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         fill_cnt_q   <= '0;
         fill_color_q <= '0;
         ram_we_q     <= 1'b0;
         ram_waddr_q  <= '0;
         ram_wdata_q  <= '0;
         pix_valid_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         fill_cnt_q   <= fill_cnt_d;
         fill_color_q <= fill_color_d;
         ram_we_q     <= ram_we_d;
         ram_waddr_q  <= ram_waddr_d;
         ram_wdata_q  <= ram_wdata_d;
         pix_valid_q  <= pix_valid_d;
      end
   end

   assign bus.ram_re    = bus.pix_req;
   assign bus.ram_raddr = bus.pix_addr;
   assign bus.pix_data  = bus.ram_rdata;
   assign bus.pix_valid = pix_valid_q;
   assign bus.wr_ready  = !full;
   assign bus.fill_busy = (state_q == FILL);
   assign bus.ram_we    = ram_we_q;
   assign bus.ram_waddr = ram_waddr_q;
   assign bus.ram_wdata = ram_wdata_q;
endmodule
